// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: debounced push-button to single-cycle advance strobe.
// A 2-flop synchronizer feeds a 4-state debounce FSM; an accepted press
// emits one registered pulse. Define BTN_AUTOREPEAT_EN to compile in the
// auto-repeat counter (first repeat after REP_DELAY, then every REP_PERIOD).
module btn_pulse_gen #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned REP_DELAY  = 1024,
    parameter int unsigned REP_PERIOD = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse,
    output logic level,
    output logic repeating
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    localparam int unsigned     DW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_bad_deb
        $error("btn_pulse_gen: DEB_CYCLES out of range 1..65535");
    end
    if (REP_DELAY < 1 || REP_DELAY > 1048575) begin : g_bad_delay
        $error("btn_pulse_gen: REP_DELAY out of range 1..2^20-1");
    end
    if (REP_PERIOD < 1 || REP_PERIOD > 1048575) begin : g_bad_period
        $error("btn_pulse_gen: REP_PERIOD out of range 1..2^20-1");
    end

    logic          sync1;
    logic          raw_s;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_cnt_nx;
    logic          press_fire;
    logic          rep_fire;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            raw_s <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            raw_s <= sync1;
        end
    end

    // Debounce next-state: count consecutive agreeing samples; the counter
    // only increments below DEB_LAST so it can never wrap
    always_comb begin
        state_nx   = state;
        deb_cnt_nx = deb_cnt;
        press_fire = 1'b0;
        case (state)
            IDLE: begin
                deb_cnt_nx = '0;
                if (raw_s) begin
                    if (DEB_CYCLES == 1) begin
                        state_nx   = HELD;
                        press_fire = 1'b1;
                    end else begin
                        state_nx   = DEB_PRESS;
                        deb_cnt_nx = DW'(1);
                    end
                end
            end
            DEB_PRESS: begin
                if (!raw_s) begin
                    state_nx   = IDLE;
                    deb_cnt_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx   = HELD;
                    deb_cnt_nx = '0;
                    press_fire = 1'b1;
                end else begin
                    deb_cnt_nx = deb_cnt + DW'(1);
                end
            end
            HELD: begin
                deb_cnt_nx = '0;
                if (!raw_s) begin
                    if (DEB_CYCLES == 1) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DEB_RELEASE;
                        deb_cnt_nx = DW'(1);
                    end
                end
            end
            default: begin
                if (raw_s) begin
                    state_nx   = HELD;
                    deb_cnt_nx = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx   = IDLE;
                    deb_cnt_nx = '0;
                end else begin
                    deb_cnt_nx = deb_cnt + DW'(1);
                end
            end
        endcase
    end

    // FSM, debounce counter, level and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            deb_cnt <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state   <= state_nx;
            deb_cnt <= deb_cnt_nx;
            level   <= (state_nx == HELD) || (state_nx == DEB_RELEASE);
            pulse   <= press_fire | rep_fire;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned   RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned   RW   = $clog2(RMAX) + 1;

    logic [RW-1:0] rep_cnt;
    logic          rep_hit;
    logic          counting;

    // Repeat target: REP_DELAY before the first repeat, REP_PERIOD after.
    // A hit while pulse is still high is deferred one cycle (counter holds)
    // so that pulse is never asserted two cycles in a row.
    always_comb begin
        counting = (state == HELD) && raw_s;
        rep_hit  = repeating ? (rep_cnt == RW'(REP_PERIOD - 1))
                             : (rep_cnt == RW'(REP_DELAY - 1));
        rep_fire = counting && rep_hit && !pulse;
    end

    // Repeat counter: restarts at the press pulse, pauses outside steady HELD,
    // clears on return to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            repeating <= 1'b0;
        end else if (press_fire || state_nx == IDLE) begin
            rep_cnt   <= '0;
            repeating <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            repeating <= 1'b1;
        end else if (counting && !rep_hit) begin
            rep_cnt   <= rep_cnt + RW'(1);
        end
    end
`else
    assign rep_fire  = 1'b0;
    assign repeating = 1'b0;
`endif

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed self-checking bench for btn_pulse_gen (DEB_CYCLES=4,
// REP_DELAY=20, REP_PERIOD=5). Auto-repeat checks are built only when
// BTN_AUTOREPEAT_EN is defined, matching the DUT build.
module tb_btn_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic pulse;
    logic level;
    logic repeating;

    int errors = 0;
    int checks = 0;

    logic       prev_pulse = 1'b0;
    int         npulse     = 0;
    logic [1:0] ucnt;

    always #5 clk = ~clk;

    btn_pulse_gen #(
        .DEB_CYCLES (4),
        .REP_DELAY  (20),
        .REP_PERIOD (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .pulse     (pulse),
        .level     (level),
        .repeating (repeating)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Downstream 2-bit up-counter advanced by pulse
    always @(posedge clk or posedge rst) begin
        if (rst) ucnt <= 2'd0;
        else if (pulse) ucnt <= ucnt + 2'd1;
    end

    // Pulse monitor: count strobes and flag back-to-back assertion
    always @(negedge clk) begin
        if (!rst) check("pulse_single", 32'(pulse & prev_pulse), 32'd0);
        prev_pulse <= pulse;
        if (pulse) npulse <= npulse + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_check(input string tag);
        btn_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check({tag, "_pulse"}, 32'(pulse), 32'(e == 6));
            check({tag, "_level"}, 32'(level), 32'(e >= 6));
        end
    endtask

    task automatic release_check(input string tag);
        btn_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check({tag, "_pulse"}, 32'(pulse), 32'd0);
            check({tag, "_level"}, 32'(level), 32'(e < 6));
            if (e >= 6) check({tag, "_rep"}, 32'(repeating), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"}, 32'(pulse), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_rep"}, 32'(repeating), 32'd0);
    endtask

    initial begin
        int p0;
        rst     = 1'b1;
        btn_raw = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Clean press: pulse one cycle after edge 6, level from edge 6
        press_check("press");

        // Release bounce while held: low for 2 samples, then high again
        btn_raw = 1'b0;
        tick();
        tick();
        btn_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("bounce_pulse", 32'(pulse), 32'd0);
            check("bounce_level", 32'(level), 32'd1);
        end

`ifndef BTN_AUTOREPEAT_EN
        // Long hold without auto-repeat: no further pulses
        for (int e = 1; e <= 40; e++) begin
            tick();
            check("hold_pulse", 32'(pulse), 32'd0);
            check("hold_rep", 32'(repeating), 32'd0);
        end
`endif

        release_check("release");
        repeat (4) tick();

        // Glitch of 3 samples: no pulse, no level change
        for (int e = 1; e <= 12; e++) begin
            btn_raw = (e <= 3);
            tick();
            check("glitch_pulse", 32'(pulse), 32'd0);
            check("glitch_level", 32'(level), 32'd0);
        end

        // Reset during DEB_PRESS
        btn_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_zero("rst_debpress");
        btn_raw = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        press_check("after_rst1");
        release_check("after_rst1_rel");
        repeat (2) tick();

        // Reset during HELD, in the very cycle the press pulse is high
        btn_raw = 1'b1;
        repeat (6) tick();
        check("held_pulse_pre_rst", 32'(pulse), 32'd1);
        rst = 1'b1;
        #1;
        check_zero("rst_held");
        btn_raw = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        press_check("after_rst2");
        release_check("after_rst2_rel");

        // Four presses driving the 2-bit counter: 01,10,11,00
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("ucnt_init", 32'(ucnt), 32'd0);
        p0 = npulse;
        for (int k = 1; k <= 4; k++) begin
            btn_raw = 1'b1;
            repeat (10) tick();
            btn_raw = 1'b0;
            repeat (10) tick();
            check("ucnt", 32'(ucnt), 32'(k % 4));
        end
        check("four_pulses", 32'(npulse - p0), 32'd4);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat: pulses at offsets 0,20,25,30,35,40 after press pulse
        btn_raw = 1'b1;
        for (int e = 1; e <= 48; e++) begin
            int off;
            logic exp_p;
            tick();
            off   = e - 6;
            exp_p = (off == 0) || (off == 20) || (off == 25) || (off == 30) ||
                    (off == 35) || (off == 40);
            check("rep_pulse", 32'(pulse), 32'(exp_p));
            check("rep_flag", 32'(repeating), 32'(off >= 20));
        end
        release_check("rep_release");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive synchronized samples needed to accept a level change; legal range 1..65535.
REQ-002 Parameter REP_DELAY, default 1024: cycles in HELD after the press pulse before the first auto-repeat pulse; legal range 1..2^20-1.
REQ-003 Parameter REP_PERIOD, default 256: cycles between auto-repeat pulses; legal range 1..2^20-1.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 btn_raw  in  1  asynchronous, bouncy push-button level (1 = pressed).
REQ-007 pulse  out  1  single-cycle advance strobe that drives the downstream 2-bit up-counter FSM input.
REQ-008 level  out  1  debounced button level.
REQ-009 repeating  out  1  high while auto-repeat pulses are being issued.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer; only the second flop output (raw_s) is used by the logic.
REQ-011 FSM states SHALL be IDLE, DEB_PRESS, HELD and DEB_RELEASE, held in a 2-bit register.
REQ-012 IDLE: raw_s=1 -> DEB_PRESS with debounce count=1; otherwise stay.
REQ-013 DEB_PRESS: raw_s=0 -> IDLE, count cleared, no pulse; raw_s=1 -> count+1.
REQ-014 At the edge that takes the DEB_CYCLES-th consecutive raw_s=1 sample: state -> HELD, level<=1, pulse<=1 for exactly one cycle.
REQ-015 With DEB_CYCLES=N and btn_raw held high, pulse SHALL be high during the cycle after edge N+2, counting the first edge that samples btn_raw=1 as edge 1.
REQ-016 HELD: raw_s=0 -> DEB_RELEASE with count=1.
REQ-017 DEB_RELEASE: raw_s=1 -> HELD, no pulse, level stays 1; DEB_CYCLES consecutive raw_s=0 samples -> IDLE, level<=0.
REQ-018 pulse SHALL be registered, never high for two consecutive cycles, and never asserted in IDLE, DEB_PRESS or DEB_RELEASE.
REQ-019 With DEB_CYCLES=1, the transition SHALL occur on the first qualifying sample; no intermediate state persists.
REQ-020 Debounce and repeat counters SHALL saturate and never wrap; widths SHALL be sized with $clog2 of the parameter +1.
REQ-021 A glitch shorter than DEB_CYCLES samples SHALL produce no pulse and no level change.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, synchronizer flops=0, all counters=0, pulse=0, level=0, repeating=0.
REQ-023 rst asserted mid-operation (any state, including mid-repeat) SHALL abort without emitting a pulse; after release, the block behaves as fresh from IDLE.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN SHALL compile the auto-repeat logic in.
REQ-025 With the macro: in HELD, a repeat counter SHALL run from the press pulse; pulse fires when it reaches REP_DELAY, then every REP_PERIOD cycles; repeating=1 from the first repeat pulse until the state leaves HELD/DEB_RELEASE.
REQ-026 With the macro, the repeat counter SHALL pause in DEB_RELEASE and resume unchanged on return to HELD; it clears on entry to IDLE.
REQ-027 Without the macro: exactly one pulse per accepted press, repeating tied to 0, and no repeat counter synthesized.

Verification
REQ-028 DEB_CYCLES=4, btn_raw 0->1 held -> pulse high exactly one cycle after edge 6; level=1 from the same edge.
REQ-029 DEB_CYCLES=4, btn_raw high 3 cycles then low -> no pulse; level stays 0.
REQ-030 Four clean presses with pulse feeding the 2-bit up-counter -> counter output sequence 00,01,10,11 returns to 00 after the 4th press; exactly four pulses.
REQ-031 BTN_AUTOREPEAT_EN, DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5, held 40 cycles after the press pulse -> pulses at offsets 0,20,25,30,35,40; repeating=1 from offset 20.
REQ-032 rst pulsed during DEB_PRESS and again during HELD -> all outputs 0 immediately, no pulse; next clean press yields one pulse at REQ-015 latency.
REQ-033 Release bounce (0 for 2 cycles, then 1) during HELD with DEB_CYCLES=4 -> no pulse, level remains 1.
